clock_mode_ctrl: RTL and testbench
==================================

# clock_mode_ctrl

Mode and alarm controller for the digital clock's seconds/minutes/hours counter. It sequences the time-set procedure: it freezes the counter, edits hour and minute, and issues a one-cycle load. It also holds the alarm time, detects the alarm match against the live counter outputs, and manages ringing, snooze and dismiss. It sits between the debounced user buttons and the time counter, in the 1 Hz domain.

## Interface
- SNOOZE_MIN, 5: snooze delay in minutes, legal range 1–59
- RING_SEC, 60: automatic ring timeout in clk_1hz cycles, range 1–255

- clk_1hz  input  1  1 Hz system clock; all logic on its rising edge
- rst  input  1  asynchronous, active-high reset
- btn_mode  input  1  debounced, synchronized level; edge-detected internally
- btn_inc  input  1  debounced, synchronized level; edge-detected internally
- btn_alarm  input  1  debounced, synchronized level; a rising edge toggles arm
- cur_sec  input  6  live seconds from the counter, 0–59
- cur_min  input  6  live minutes from the counter, 0–59
- cur_hour  input  5  live hours from the counter, 0–23
- run_en  output  1  counter count enable
- load  output  1  one-cycle strobe: counter takes load_hour:load_min and sets sec to 0
- load_hour  output  5  hour value to load
- load_min  output  6  minute value to load
- alarm_hour  output  5  stored alarm hour
- alarm_min  output  6  stored alarm minute
- alarm_armed  output  1  alarm enabled
- ringing  output  1  alarm active
- state  output  3  current mode, encoded per Operation

## Operation
- Edge detect:
  - Each button has a prev register.
  - Event = level & ~prev.
  - prev resets to 0, so a button held through reset generates an event on the first edge after reset.
- FSM states: RUN=0, SET_HOUR=1, SET_MIN=2, SET_AHOUR=3, SET_AMIN=4. Codes 5–7 go to RUN on the next edge.
- Mode events, when not ringing:
  - RUN→SET_HOUR: copy cur_hour and cur_min into edit_hour and edit_min.
  - SET_HOUR→SET_MIN.
  - SET_MIN→SET_AHOUR: registered load=1, load_hour=edit_hour, load_min=edit_min.
  - SET_AHOUR→SET_AMIN.
  - SET_AMIN→RUN.
- Inc events, when not ringing:
  - SET_HOUR: edit_hour +1, wraps 23→0.
  - SET_MIN: edit_min +1, wraps 59→0.
  - SET_AHOUR: alarm_hour +1, wraps 23→0.
  - SET_AMIN: alarm_min +1, wraps 59→0.
  - RUN: no effect.
- Mode and inc events in the same cycle: the mode event is taken and the inc event is dropped.
- run_en = 0 in SET_HOUR and SET_MIN, 1 otherwise. It is decoded from the state register.
- Alarm event toggles alarm_armed in any state.
  - Disarming clears ringing, the ring timer and snooze_pending in the same edge.
  - If disarm coincides with a ring trigger, disarm wins.
- Ring trigger, evaluated only in state RUN with alarm_armed=1 and cur_sec==0. Either condition fires:
  - cur_hour:cur_min == alarm_hour:alarm_min, or
  - snooze_pending=1 and cur_hour:cur_min == snz_hour:snz_min.
  - On trigger: ringing goes to 1 on that edge, the ring timer loads 0, and snooze_pending clears.
  - A match while in any set state is missed, not deferred.
- While ringing, button events are consumed by the alarm and the FSM ignores them:
  - Inc event = snooze. ringing→0, snooze_pending→1, and snooze target = cur_hour:cur_min + SNOOZE_MIN. If minutes exceed 59, subtract 60 and add 1 hour, with hour wrapping 23→0.
  - Mode event = dismiss. ringing→0, snooze_pending→0.
  - Ring timer reaching RING_SEC−1 ends ringing with no snooze.
- Reset values:
  - state=RUN, run_en=1.
  - load=0, load_hour=0, load_min=0.
  - alarm_hour=0, alarm_min=0, alarm_armed=0.
  - ringing=0, snooze_pending=0, snooze target 0, ring timer 0.
  - edit registers 0, prev registers 0.
- Reset mid-edit abandons the edit. No load is issued.

## Timing
- Button level change → event seen on the next edge → state and outputs update on that same edge. Latency from edge detect to output: 1 cycle.
- load is high for exactly 1 cycle, the first cycle in SET_AHOUR. The counter captures it on the following edge.
- run_en drops on the edge that enters SET_HOUR. While in SET_HOUR and SET_MIN the counter holds the frozen time.
- ringing asserts on the edge where cur_sec==0 matches. It lasts at most RING_SEC cycles.

## Test plan
- Reset with btn_mode=0 → state=0, run_en=1, load=0, alarm_armed=0, ringing=0.
- Counter at 13:45. Mode event; inc ×12 (hour 13→1 via the 23→0 wrap); mode; inc ×20 (minute 45→5); mode → exactly one load pulse with load_hour=1, load_min=5. run_en=0 in SET_HOUR and SET_MIN.
- Mode and inc asserted in the same cycle in SET_HOUR → state=SET_MIN, edit_hour unchanged.
- Set alarm to 07:30 and arm. Drive cur 07:30:00 in RUN → ringing=1 at that edge. ringing=0 after 60 cycles (default RING_SEC).
- Alarm 23:58 ringing at 23:58:00. Inc event → snooze target 00:03. Drive cur 00:03:00 → ringing=1 again.
- Ringing at 07:30:05. Mode event → ringing=0, state stays RUN. Repeat the ring, then send an alarm event → alarm_armed=0 and ringing=0 on the same edge.

Source files
------------

// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - time-set sequencing, alarm storage, ring/snooze/dismiss for the 1 Hz clock counter
module clock_mode_ctrl #(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60
) (
  input  logic       clk_1hz,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_alarm,
  input  logic [5:0] cur_sec,
  input  logic [5:0] cur_min,
  input  logic [4:0] cur_hour,
  output logic       run_en,
  output logic       load,
  output logic [4:0] load_hour,
  output logic [5:0] load_min,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic       alarm_armed,
  output logic       ringing,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SET_HOUR  = 3'd1,
    SET_MIN   = 3'd2,
    SET_AHOUR = 3'd3,
    SET_AMIN  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic       prev_mode, prev_inc, prev_alarm;
  logic       ev_mode, ev_inc, ev_alarm;
  logic       fsm_mode, fsm_inc;
  logic [4:0] edit_hour, edit_hour_d;
  logic [5:0] edit_min, edit_min_d;
  logic       load_d;
  logic [4:0] alarm_hour_d;
  logic [5:0] alarm_min_d;
  logic       armed_d, ringing_d;
  logic [7:0] ring_timer, ring_timer_d;
  logic       snooze_pending, snooze_pending_d;
  logic [4:0] snz_hour, snz_hour_d;
  logic [5:0] snz_min, snz_min_d;
  logic [6:0] snz_sum;
  logic       trigger;

  function automatic logic [4:0] hour_inc(input logic [4:0] h);
    return (h == 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] min_inc(input logic [5:0] m);
    return (m == 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  assign ev_mode  = btn_mode & ~prev_mode;
  assign ev_inc   = btn_inc & ~prev_inc;
  assign ev_alarm = btn_alarm & ~prev_alarm;

  // While ringing the alarm owns mode/inc; a mode press always beats inc
  assign fsm_mode = ev_mode & ~ringing;
  assign fsm_inc  = ev_inc & ~ringing & ~ev_mode;

  assign state  = state_q;
  assign run_en = !((state_q == SET_HOUR) || (state_q == SET_MIN));

  always_comb begin
    state_d      = state_q;
    edit_hour_d  = edit_hour;
    edit_min_d   = edit_min;
    alarm_hour_d = alarm_hour;
    alarm_min_d  = alarm_min;
    load_d       = 1'b0;
    case (state_q)
      RUN: begin
        if (fsm_mode) begin
          state_d     = SET_HOUR;
          edit_hour_d = cur_hour;
          edit_min_d  = cur_min;
        end
      end
      SET_HOUR: begin
        if (fsm_mode)     state_d = SET_MIN;
        else if (fsm_inc) edit_hour_d = hour_inc(edit_hour);
      end
      SET_MIN: begin
        if (fsm_mode) begin
          state_d = SET_AHOUR;
          load_d  = 1'b1;
        end else if (fsm_inc) begin
          edit_min_d = min_inc(edit_min);
        end
      end
      SET_AHOUR: begin
        if (fsm_mode)     state_d = SET_AMIN;
        else if (fsm_inc) alarm_hour_d = hour_inc(alarm_hour);
      end
      SET_AMIN: begin
        if (fsm_mode)     state_d = RUN;
        else if (fsm_inc) alarm_min_d = min_inc(alarm_min);
      end
      default: state_d = RUN;
    endcase
  end

  assign snz_sum = {1'b0, cur_min} + 7'(SNOOZE_MIN);
  assign trigger = (state_q == RUN) && alarm_armed && (cur_sec == 6'd0) &&
                   (((cur_hour == alarm_hour) && (cur_min == alarm_min)) ||
                    (snooze_pending && (cur_hour == snz_hour) && (cur_min == snz_min)));

  always_comb begin
    armed_d          = alarm_armed ^ ev_alarm;
    ringing_d        = ringing;
    ring_timer_d     = ring_timer;
    snooze_pending_d = snooze_pending;
    snz_hour_d       = snz_hour;
    snz_min_d        = snz_min;
    if (ev_alarm && alarm_armed) begin
      ringing_d        = 1'b0;
      ring_timer_d     = 8'd0;
      snooze_pending_d = 1'b0;
    end else if (ringing) begin
      if (ev_mode) begin
        ringing_d        = 1'b0;
        ring_timer_d     = 8'd0;
        snooze_pending_d = 1'b0;
      end else if (ev_inc) begin
        ringing_d        = 1'b0;
        ring_timer_d     = 8'd0;
        snooze_pending_d = 1'b1;
        if (snz_sum > 7'd59) begin
          snz_min_d  = 6'(snz_sum - 7'd60);
          snz_hour_d = hour_inc(cur_hour);
        end else begin
          snz_min_d  = snz_sum[5:0];
          snz_hour_d = cur_hour;
        end
      end else if (ring_timer == 8'(RING_SEC - 1)) begin
        ringing_d    = 1'b0;
        ring_timer_d = 8'd0;
      end else begin
        ring_timer_d = ring_timer + 8'd1;
      end
    end else if (trigger) begin
      ringing_d        = 1'b1;
      ring_timer_d     = 8'd0;
      snooze_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_1hz or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      prev_mode      <= 1'b0;
      prev_inc       <= 1'b0;
      prev_alarm     <= 1'b0;
      edit_hour      <= 5'd0;
      edit_min       <= 6'd0;
      load           <= 1'b0;
      load_hour      <= 5'd0;
      load_min       <= 6'd0;
      alarm_hour     <= 5'd0;
      alarm_min      <= 6'd0;
      alarm_armed    <= 1'b0;
      ringing        <= 1'b0;
      ring_timer     <= 8'd0;
      snooze_pending <= 1'b0;
      snz_hour       <= 5'd0;
      snz_min        <= 6'd0;
    end else begin
      state_q        <= state_d;
      prev_mode      <= btn_mode;
      prev_inc       <= btn_inc;
      prev_alarm     <= btn_alarm;
      edit_hour      <= edit_hour_d;
      edit_min       <= edit_min_d;
      load           <= load_d;
      if (load_d) begin
        load_hour <= edit_hour;
        load_min  <= edit_min;
      end
      alarm_hour     <= alarm_hour_d;
      alarm_min      <= alarm_min_d;
      alarm_armed    <= armed_d;
      ringing        <= ringing_d;
      ring_timer     <= ring_timer_d;
      snooze_pending <= snooze_pending_d;
      snz_hour       <= snz_hour_d;
      snz_min        <= snz_min_d;
    end
  end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb/tb_clock_mode_ctrl.sv - directed and randomized checks of clock_mode_ctrl against a minute-of-day model
module tb_clock_mode_ctrl;
  localparam int SNOOZE_MIN = 5;
  localparam int RING_SEC   = 60;

  logic       clk_1hz = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_alarm = 1'b0;
  logic [5:0] cur_sec = 6'd10, cur_min = 6'd45;
  logic [4:0] cur_hour = 5'd13;
  logic       run_en, load, alarm_armed, ringing;
  logic [4:0] load_hour, alarm_hour;
  logic [5:0] load_min, alarm_min;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  // Model: mode index, times as plain integers, ring age in elapsed cycles
  int m_state, m_edit_h, m_edit_m, m_ah, m_am, m_lh, m_lm, m_age, m_snz;
  bit m_load, m_armed, m_ring, m_pend, pm, pi, pa;

  clock_mode_ctrl #(.SNOOZE_MIN(SNOOZE_MIN), .RING_SEC(RING_SEC)) dut (
    .clk_1hz(clk_1hz), .rst(rst),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_alarm(btn_alarm),
    .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
    .run_en(run_en), .load(load), .load_hour(load_hour), .load_min(load_min),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .alarm_armed(alarm_armed), .ringing(ringing), .state(state)
  );

  always #5 clk_1hz = ~clk_1hz;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_edit_h = 0; m_edit_m = 0; m_ah = 0; m_am = 0;
    m_lh = 0; m_lm = 0; m_age = 0; m_snz = 0;
    m_load = 0; m_armed = 0; m_ring = 0; m_pend = 0; pm = 0; pi = 0; pa = 0;
  endtask

  task automatic model_step();
    bit ev_m, ev_i, ev_a, old_ring, old_armed, trig;
    int cur_t;
    ev_m = btn_mode && !pm; ev_i = btn_inc && !pi; ev_a = btn_alarm && !pa;
    pm = btn_mode; pi = btn_inc; pa = btn_alarm;
    old_ring = m_ring; old_armed = m_armed;
    cur_t = int'(cur_hour) * 60 + int'(cur_min);
    trig = (m_state == 0) && old_armed && (cur_sec == 0) &&
           ((cur_t == m_ah * 60 + m_am) || (m_pend && cur_t == m_snz));
    m_load = 0;
    if (ev_m && !old_ring) begin
      if (m_state == 0) begin
        m_edit_h = int'(cur_hour); m_edit_m = int'(cur_min);
      end
      if (m_state == 2) begin
        m_load = 1; m_lh = m_edit_h; m_lm = m_edit_m;
      end
      m_state = (m_state + 1) % 5;
    end else if (ev_i && !old_ring) begin
      case (m_state)
        1: m_edit_h = (m_edit_h + 1) % 24;
        2: m_edit_m = (m_edit_m + 1) % 60;
        3: m_ah = (m_ah + 1) % 24;
        4: m_am = (m_am + 1) % 60;
        default: ;
      endcase
    end
    if (ev_a && old_armed) begin
      m_armed = 0; m_ring = 0; m_pend = 0; m_age = 0;
    end else begin
      if (ev_a) m_armed = 1;
      if (old_ring) begin
        if (ev_m) begin
          m_ring = 0; m_pend = 0;
        end else if (ev_i) begin
          m_ring = 0; m_pend = 1; m_snz = (cur_t + SNOOZE_MIN) % 1440;
        end else if (m_age >= RING_SEC) begin
          m_ring = 0;
        end else begin
          m_age++;
        end
      end else if (trig) begin
        m_ring = 1; m_age = 1; m_pend = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("state", int'(state), m_state);
    chk("run_en", int'(run_en), int'(m_state != 1 && m_state != 2));
    chk("load", int'(load), int'(m_load));
    chk("load_hour", int'(load_hour), m_lh);
    chk("load_min", int'(load_min), m_lm);
    chk("alarm_hour", int'(alarm_hour), m_ah);
    chk("alarm_min", int'(alarm_min), m_am);
    chk("alarm_armed", int'(alarm_armed), int'(m_armed));
    chk("ringing", int'(ringing), int'(m_ring));
  endtask

  task automatic tick();
    @(posedge clk_1hz);
    if (!rst) model_step();
    #1;
    compare_all();
  endtask

  task automatic press(input bit m, input bit i, input bit a);
    btn_mode = m; btn_inc = i; btn_alarm = a;
    tick();
    btn_mode = 0; btn_inc = 0; btn_alarm = 0;
    tick();
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
  endtask

  initial begin
    #1;
    model_reset();
    compare_all();
    chk("rst_state", int'(state), 0);
    chk("rst_run_en", int'(run_en), 1);
    chk("rst_load", int'(load), 0);
    chk("rst_armed", int'(alarm_armed), 0);
    chk("rst_ringing", int'(ringing), 0);
    tick(); tick();
    rst = 0;

    // Time set from 13:45 to 01:05, mode+inc together leaving SET_HOUR
    press(1, 0, 0);
    chk("set_hour_state", int'(state), 1);
    chk("set_hour_run_en", int'(run_en), 0);
    repeat (12) press(0, 1, 0);
    press(1, 1, 0);
    chk("set_min_state", int'(state), 2);
    chk("set_min_run_en", int'(run_en), 0);
    repeat (20) press(0, 1, 0);
    btn_mode = 1; tick();
    chk("load_pulse", int'(load), 1);
    chk("load_hour_lit", int'(load_hour), 1);
    chk("load_min_lit", int'(load_min), 5);
    chk("ahour_run_en", int'(run_en), 1);
    btn_mode = 0; tick();
    chk("load_one_cycle", int'(load), 0);

    // Alarm 07:30, arm, ring and time out
    repeat (7) press(0, 1, 0);
    press(1, 0, 0);
    repeat (30) press(0, 1, 0);
    press(1, 0, 0);
    chk("alarm_hour_lit", int'(alarm_hour), 7);
    chk("alarm_min_lit", int'(alarm_min), 30);
    press(0, 0, 1);
    chk("armed_lit", int'(alarm_armed), 1);
    set_cur(7, 30, 0); tick();
    chk("ring_start", int'(ringing), 1);
    cur_sec = 6'd1;
    repeat (RING_SEC - 1) tick();
    chk("ring_last_cycle", int'(ringing), 1);
    tick();
    chk("ring_timeout", int'(ringing), 0);

    // Alarm 23:58 and snooze across midnight
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    repeat (16) press(0, 1, 0);
    press(1, 0, 0);
    repeat (28) press(0, 1, 0);
    press(1, 0, 0);
    chk("alarm2_hour", int'(alarm_hour), 23);
    chk("alarm2_min", int'(alarm_min), 58);
    set_cur(23, 58, 0); tick();
    chk("ring2_start", int'(ringing), 1);
    cur_sec = 6'd1;
    press(0, 1, 0);
    chk("snooze_stop", int'(ringing), 0);
    set_cur(0, 2, 0); tick();
    chk("snooze_early", int'(ringing), 0);
    set_cur(0, 3, 0); tick();
    chk("snooze_ring", int'(ringing), 1);
    cur_sec = 6'd5;
    press(1, 0, 0);
    chk("dismiss_ring", int'(ringing), 0);
    chk("dismiss_state", int'(state), 0);
    set_cur(23, 58, 0); tick();
    chk("ring3_start", int'(ringing), 1);
    cur_sec = 6'd1;
    btn_alarm = 1; tick();
    chk("disarm_armed", int'(alarm_armed), 0);
    chk("disarm_ringing", int'(ringing), 0);
    btn_alarm = 0; tick();

    // Randomized phase with occasional asynchronous reset
    for (int c = 0; c < 5000; c++) begin
      int r;
      if ($urandom_range(0, 3) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 2) == 0) btn_inc = ~btn_inc;
      if ($urandom_range(0, 9) == 0) btn_alarm = ~btn_alarm;
      r = $urandom_range(0, 5);
      if (r < 2)       set_cur(m_ah, m_am, 0);
      else if (r == 2) set_cur(m_snz / 60, m_snz % 60, 0);
      else             set_cur($urandom_range(0, 23), $urandom_range(0, 59), 0);
      if ($urandom_range(0, 1) == 1) cur_sec = 6'($urandom_range(1, 59));
      if ($urandom_range(0, 599) == 0) begin
        rst = 1; #1;
        model_reset();
        compare_all();
        tick();
        rst = 0;
      end else begin
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
